// File: rtl/mul16_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// mul16_share_arbiter_if
// Purpose : bundles the request, response and multiplier-unit signals of
//           mul16_share_arbiter into one port.
// Signals :
//   req_valid/req_ready [NREQ]   per-requester handshake
//   req_a/req_b [16*NREQ]        operands, requester k at [16k+15:16k]
//   rsp_valid/rsp_ready          result handshake
//   rsp_id [IDW], rsp_data [32]  result owner and unsigned product
//   mul_start, mul_ain, mul_bin  drive to the shared shift-add unit
//   mul_yout [32], mul_done      accumulator and completion from the unit
//   busy                         arbiter not idle
// Modports: slave = the arbiter, master = clients plus the multiplier unit.
// ---------------------------------------------------------------------------
interface mul16_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [16*NREQ-1:0] req_a;
  logic [16*NREQ-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_data;
  logic               mul_start;
  logic [15:0]        mul_ain;
  logic [15:0]        mul_bin;
  logic [31:0]        mul_yout;
  logic               mul_done;
  logic               busy;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mul_yout, mul_done,
    output req_ready, rsp_valid, rsp_id, rsp_data, mul_start, mul_ain, mul_bin, busy
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, mul_yout, mul_done,
    input  req_ready, rsp_valid, rsp_id, rsp_data, mul_start, mul_ain, mul_bin, busy
  );
endinterface

// File: rtl/mul16_share_arbiter.sv
// ---------------------------------------------------------------------------
// mul16_share_arbiter
// Purpose : shares one sequential 16x16 shift-add multiplier among NREQ
//           requesters with round-robin grant. The granted operands are held
//           on the unit for the whole run, the product is recovered as the
//           accumulator delta (the unit never clears itself) and returned
//           tagged with the requester index.
// Ports   :
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    mul16_share_arbiter_if.slave (request, response, unit signals)
// Option  : MUL_ARB_ZERO_BYPASS_EN - when defined, an accepted op with a zero
//           operand skips the unit and responds with 0 on the next edge.
// ---------------------------------------------------------------------------
module mul16_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mul16_share_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  logic [1:0]     r_state;
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] r_rsp_id;
  logic           r_rsp_valid;
  logic [31:0]    r_rsp_data;
  logic [31:0]    r_base;
  logic           r_mul_start;
  logic [15:0]    r_ain;
  logic [15:0]    r_bin;
  logic           r_busy;

  logic           w_grant_found;
  logic [IDW-1:0] w_grant_idx;
  logic [IDW-1:0] w_next_ptr;
  logic [15:0]    w_sel_a;
  logic [15:0]    w_sel_b;

  // (base + off) mod NREQ for base < NREQ and off <= NREQ
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) begin
      s = s - NREQ;
    end else begin
      s = s;
    end
    return IDW'(s);
  endfunction

  // Round-robin search starting at the pointer
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_grant_found && bus.req_valid[wrap_add(r_rr_ptr, i)]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = wrap_add(r_rr_ptr, i);
      end else begin
        w_grant_found = w_grant_found;
      end
    end
  end

  // Operand mux and next pointer for the winning requester
  always_comb begin
    w_next_ptr = wrap_add(w_grant_idx, 1);
    w_sel_a    = bus.req_a[int'(w_grant_idx)*16 +: 16];
    w_sel_b    = bus.req_b[int'(w_grant_idx)*16 +: 16];
  end

  // Accept is offered only in IDLE and is forced low while reset is held
  always_comb begin
    if (rst_n && (r_state == S_IDLE) && w_grant_found) begin
      bus.req_ready = ONE_HOT0 << w_grant_idx;
    end else begin
      bus.req_ready = '0;
    end
  end

  // Main sequencer: IDLE -> RUN -> RESP -> IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_rsp_id    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 32'd0;
      r_base      <= 32'd0;
      r_mul_start <= 1'b0;
      r_ain       <= 16'd0;
      r_bin       <= 16'd0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_found) begin
            r_ain    <= w_sel_a;
            r_bin    <= w_sel_b;
            r_rsp_id <= w_grant_idx;
            r_rr_ptr <= w_next_ptr;
            r_busy   <= 1'b1;
`ifdef MUL_ARB_ZERO_BYPASS_EN
            if ((w_sel_a == 16'd0) || (w_sel_b == 16'd0)) begin
              r_rsp_data  <= 32'd0;
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end else begin
              r_base  <= bus.mul_yout;
              r_state <= S_RUN;
            end
`else
            r_base  <= bus.mul_yout;
            r_state <= S_RUN;
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (bus.mul_done) begin
            // Unit accumulator is cumulative, so the product is the delta
            r_rsp_data  <= bus.mul_yout - r_base;
            r_rsp_valid <= 1'b1;
            r_mul_start <= 1'b0;
            r_state     <= S_RESP;
          end else begin
            r_mul_start <= 1'b1;
          end
        end
        S_RESP: begin
          // Start held low here so the unit's step counter clears between ops
          r_mul_start <= 1'b0;
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_state <= S_RESP;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
          r_mul_start <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.mul_start = r_mul_start;
  assign bus.mul_ain   = r_ain;
  assign bus.mul_bin   = r_bin;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_mul16_share_arbiter.sv
// Directed bench for mul16_share_arbiter with a behavioural shift-add unit.
module tb_mul16_share_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   lat;
  int   starts;

  mul16_share_arbiter_if #(.NREQ(4), .IDW(2)) ifc ();

  mul16_share_arbiter #(.NREQ(4), .IDW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  // Shared multiplier model: one shift-add step per clock with start high,
  // done after 16 steps, accumulator never cleared.
  logic [31:0] u_acc = 32'h1234_5678;
  logic [4:0]  u_cnt = 5'd0;

  always @(posedge clk) begin
    if (ifc.mul_start) begin
      if (u_cnt < 5'd16) begin
        if (ifc.mul_bin[u_cnt[3:0]]) begin
          u_acc <= u_acc + ({16'd0, ifc.mul_ain} << u_cnt);
        end
        u_cnt <= u_cnt + 5'd1;
      end
    end else begin
      u_cnt <= 5'd0;
    end
  end

  assign ifc.mul_yout = u_acc;
  assign ifc.mul_done = ifc.mul_start && (u_cnt == 5'd16);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Steps until rsp_valid; lat = edges taken, starts = cycles mul_start seen high
  task automatic wait_rsp(output int l, output int s);
    l = 0;
    s = 0;
    while (ifc.rsp_valid !== 1'b1 && l < 100) begin
      step();
      l++;
      if (ifc.mul_start === 1'b1) s++;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, {28'd0, ifc.req_ready}, 32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, ifc.rsp_valid}, 32'd0);
    chk({tag, "_rsp_id"},    {30'd0, ifc.rsp_id},    32'd0);
    chk({tag, "_rsp_data"},  ifc.rsp_data,           32'd0);
    chk({tag, "_mul_start"}, {31'd0, ifc.mul_start}, 32'd0);
    chk({tag, "_mul_ain"},   {16'd0, ifc.mul_ain},   32'd0);
    chk({tag, "_mul_bin"},   {16'd0, ifc.mul_bin},   32'd0);
    chk({tag, "_busy"},      {31'd0, ifc.busy},      32'd0);
  endtask

  logic [31:0] exp_d2 [5] = '{32'd20, 32'd30, 32'd40, 32'd50, 32'd20};
  logic [31:0] exp_i2 [5] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};

  initial begin
    ifc.req_valid = 4'b0000;
    ifc.req_a     = 64'd0;
    ifc.req_b     = 64'd0;
    ifc.rsp_ready = 1'b1;

    // Reset state
    #2;
    chk_all_zero("reset");
    step();
    step();
    rst_n = 1'b1;

    // 1: single op 3*5 from requester 0
    ifc.req_valid = 4'b0001;
    ifc.req_a     = {16'd0, 16'd0, 16'd0, 16'd3};
    ifc.req_b     = {16'd0, 16'd0, 16'd0, 16'd5};
    #1;
    chk("t1_req_ready", {28'd0, ifc.req_ready}, 32'h1);
    step();
    ifc.req_valid = 4'b0000;
    chk("t1_busy", {31'd0, ifc.busy}, 32'd1);
    wait_rsp(lat, starts);
    chk("t1_latency", lat, 32'd18);
    chk("t1_start_cycles", starts, 32'd17);
    chk("t1_id", {30'd0, ifc.rsp_id}, 32'd0);
    chk("t1_data", ifc.rsp_data, 32'd15);
    chk("t1_ain_held", {16'd0, ifc.mul_ain}, 32'd3);
    chk("t1_bin_held", {16'd0, ifc.mul_bin}, 32'd5);
    step();
    chk("t1_rsp_drop", {31'd0, ifc.rsp_valid}, 32'd0);
    chk("t1_idle", {31'd0, ifc.busy}, 32'd0);

    // 2: all four requesting, pointer rotates and wraps
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    ifc.req_valid = 4'b1111;
    ifc.req_a     = {16'd5, 16'd4, 16'd3, 16'd2};
    ifc.req_b     = {16'd10, 16'd10, 16'd10, 16'd10};
    for (int i = 0; i < 5; i++) begin
      step();
      wait_rsp(lat, starts);
      chk($sformatf("t2_id%0d", i), {30'd0, ifc.rsp_id}, exp_i2[i]);
      chk($sformatf("t2_data%0d", i), ifc.rsp_data, exp_d2[i]);
      step();
    end
    ifc.req_valid = 4'b0000;

    // 3: back-to-back 0xFFFF*0xFFFF (req 2) then 2*3 (req 3)
    ifc.req_valid = 4'b0100;
    ifc.req_a     = {16'd0, 16'hFFFF, 16'd0, 16'd0};
    ifc.req_b     = {16'd0, 16'hFFFF, 16'd0, 16'd0};
    step();
    ifc.req_valid = 4'b1000;
    ifc.req_a     = {16'd2, 16'd0, 16'd0, 16'd0};
    ifc.req_b     = {16'd3, 16'd0, 16'd0, 16'd0};
    wait_rsp(lat, starts);
    chk("t3_id_big", {30'd0, ifc.rsp_id}, 32'd2);
    chk("t3_data_big", ifc.rsp_data, 32'hFFFE_0001);
    step();
    step();
    ifc.req_valid = 4'b0000;
    wait_rsp(lat, starts);
    chk("t3_id_small", {30'd0, ifc.rsp_id}, 32'd3);
    chk("t3_data_small", ifc.rsp_data, 32'd6);
    step();

    // 4: response back-pressure for 10 clocks
    ifc.rsp_ready = 1'b0;
    ifc.req_valid = 4'b0011;
    ifc.req_a     = {16'd0, 16'd0, 16'd0, 16'd100};
    ifc.req_b     = {16'd0, 16'd0, 16'd0, 16'd200};
    step();
    wait_rsp(lat, starts);
    chk("t4_latency", lat, 32'd18);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("t4_valid%0d", i), {31'd0, ifc.rsp_valid}, 32'd1);
      chk($sformatf("t4_id%0d", i), {30'd0, ifc.rsp_id}, 32'd0);
      chk($sformatf("t4_data%0d", i), ifc.rsp_data, 32'd20000);
      chk($sformatf("t4_ready%0d", i), {28'd0, ifc.req_ready}, 32'd0);
      chk($sformatf("t4_start%0d", i), {31'd0, ifc.mul_start}, 32'd0);
    end
    ifc.rsp_ready = 1'b1;
    step();
    chk("t4_rsp_drop", {31'd0, ifc.rsp_valid}, 32'd0);
    chk("t4_rr_next", {28'd0, ifc.req_ready}, 32'h2);
    ifc.req_valid = 4'b0000;

    // 5: asynchronous reset during RUN abandons the op
    ifc.req_valid = 4'b0100;
    ifc.req_a     = {16'd0, 16'd11, 16'd0, 16'd0};
    ifc.req_b     = {16'd0, 16'd13, 16'd0, 16'd0};
    step();
    for (int i = 0; i < 8; i++) step();
    chk("t5_running", {31'd0, ifc.mul_start}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("t5_async");
    step();
    step();
    chk("t5_no_rsp", {31'd0, ifc.rsp_valid}, 32'd0);
    rst_n = 1'b1;
    ifc.req_valid = 4'b0010;
    ifc.req_a     = {16'd0, 16'd0, 16'd7, 16'd0};
    ifc.req_b     = {16'd0, 16'd0, 16'd9, 16'd0};
    #1;
    chk("t5_req_ready", {28'd0, ifc.req_ready}, 32'h2);
    step();
    ifc.req_valid = 4'b0000;
    wait_rsp(lat, starts);
    chk("t5_latency", lat, 32'd18);
    chk("t5_id", {30'd0, ifc.rsp_id}, 32'd1);
    chk("t5_data", ifc.rsp_data, 32'd63);
    step();

    // 6: zero operand 0*7 from requester 2
    ifc.req_valid = 4'b0100;
    ifc.req_a     = {16'd0, 16'd0, 16'd0, 16'd0};
    ifc.req_b     = {16'd0, 16'd7, 16'd0, 16'd0};
    #1;
    chk("t6_req_ready", {28'd0, ifc.req_ready}, 32'h4);
    step();
    ifc.req_valid = 4'b0000;
    wait_rsp(lat, starts);
`ifdef MUL_ARB_ZERO_BYPASS_EN
    chk("t6_latency", lat, 32'd0);
    chk("t6_start_cycles", starts, 32'd0);
    chk("t6_start_low", {31'd0, ifc.mul_start}, 32'd0);
`else
    chk("t6_latency", lat, 32'd18);
    chk("t6_start_cycles", starts, 32'd17);
`endif
    chk("t6_id", {30'd0, ifc.rsp_id}, 32'd2);
    chk("t6_data", ifc.rsp_data, 32'd0);
    step();
    chk("t6_rsp_drop", {31'd0, ifc.rsp_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
